// File: rtl/inert_poll_pkg.sv
// Shared types and constants for the inertial sensor polling sequencer:
// FSM state encoding, the register-init write table and the read-command
// builder used by the burst reader.
package inert_poll_pkg;

    typedef enum logic [2:0] {
        INIT,
        SETTLE,
        IDLE,
        RD,
        PUB
    } state_t;

    localparam int unsigned INIT_LEN = 4;

    localparam logic [15:0] INIT_CMDS [INIT_LEN] = '{
        16'h0D02, 16'h1053, 16'h1150, 16'h1460
    };

    // Read command: bit 15 flags a read, [14:8] register address, dummy 0xFF
    function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
        logic [7:0] w_hi;
        w_hi = addr | 8'h80;
        return {w_hi, 8'hFF};
    endfunction

endpackage

// File: rtl/inert_sync2.sv
// Two-flop synchroniser for the asynchronous sensor INT line, plus a third
// flop giving a one-cycle pulse on each synchronised rising edge.
module inert_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Synchroniser chain and edge-detect delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/inert_poll_seq.sv
// SPI polling sequencer for the inertial sensor. After reset it writes the
// init table, waits 2^SETTLE_W cycles, then on every synchronised INT edge
// burst-reads NUM_CH 16-bit channels byte by byte and publishes the full set
// with a one-cycle vld pulse.
// Optional build macro: INERT_WDOG_EN enables the idle watchdog (stale flag).
module inert_poll_seq
    import inert_poll_pkg::*;
#(
    parameter int unsigned          NUM_CH   = 4,
    parameter logic [NUM_CH*8-1:0]  CH_ADDR  = {8'h2C, 8'h2A, 8'h26, 8'h24},
    parameter int unsigned          SETTLE_W = 16,
    parameter int unsigned          TMO_W    = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INT,
    output logic                 wrt,
    output logic [15:0]          cmd,
    input  logic                 done,
    input  logic [15:0]          rd_data,
    output logic [NUM_CH*16-1:0] ch_data,
    output logic                 vld,
    output logic                 ovr,
    input  logic                 clr_ovr,
    output logic                 stale
);

    localparam int unsigned NB = 2 * NUM_CH;
    localparam int unsigned BW = $clog2(NB);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
    localparam logic [1:0]    LAST_INIT = 2'(INIT_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_rise;
    logic                  r_pend;
    logic                  r_wrt;
    logic [15:0]           r_cmd;
    logic                  w_issue;
    logic [15:0]           w_cmd_nxt;
    logic                  w_xfer_done;
    logic [1:0]            r_init_idx;
    logic [SETTLE_W-1:0]   r_settle;
    logic [BW-1:0]         r_byte;
    logic [7:0]            w_addr;
    logic [NUM_CH*16-1:0]  r_shadow;
    logic [NUM_CH*16-1:0]  w_shadow_nxt;
    logic [NUM_CH*16-1:0]  r_ch_data;
    logic                  r_vld;
    logic                  r_ovr;
    logic                  w_unused_rd;

    assign w_unused_rd = &{1'b0, rd_data[15:8]};

    inert_sync2 u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(INT),
        .o_rise (w_rise)
    );

    assign w_xfer_done = r_pend & done;

    // Register address for the current byte: channel base, +1 for high byte
    always_comb begin
        w_addr = CH_ADDR[{r_byte >> 1, 3'b000} +: 8] + {7'd0, r_byte[0]};
    end

    // Next-state and SPI issue decode
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_cmd_nxt   = r_cmd;
        case (r_state)
            INIT: begin
                if (!r_pend) begin
                    w_issue   = 1'b1;
                    w_cmd_nxt = INIT_CMDS[r_init_idx];
                end else if (done && (r_init_idx == LAST_INIT)) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle == '1) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = RD;
                end
            end
            RD: begin
                if (!r_pend) begin
                    w_issue   = 1'b1;
                    w_cmd_nxt = rd_cmd(w_addr);
                end else if (done && (r_byte == LAST_BYTE)) begin
                    w_state_nxt = PUB;
                end
            end
            PUB: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // Shadow image with the byte arriving this cycle merged in, so the
    // publish on the final done already includes the last byte
    always_comb begin
        w_shadow_nxt = r_shadow;
        if ((r_state == RD) && w_xfer_done) begin
            w_shadow_nxt[{r_byte, 3'b000} +: 8] = rd_data[7:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SPI handshake: one-cycle wrt, command held while the transaction pends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrt  <= 1'b0;
            r_cmd  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_wrt <= w_issue;
            if (w_issue) begin
                r_cmd  <= w_cmd_nxt;
                r_pend <= 1'b1;
            end else if (done) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Init-table index, saturating at the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_idx <= '0;
        end else if ((r_state == INIT) && w_xfer_done && (r_init_idx != LAST_INIT)) begin
            r_init_idx <= r_init_idx + 2'd1;
        end
    end

    // Settle counter runs only while in SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (r_state == SETTLE) begin
            r_settle <= r_settle + 1'b1;
        end else begin
            r_settle <= '0;
        end
    end

    // Burst byte index, rearmed in IDLE and saturating at the last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte <= '0;
        end else if (r_state == IDLE) begin
            r_byte <= '0;
        end else if ((r_state == RD) && w_xfer_done && (r_byte != LAST_BYTE)) begin
            r_byte <= r_byte + 1'b1;
        end
    end

    // Shadow capture and atomic publish into ch_data with vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_ch_data <= '0;
            r_vld     <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_vld    <= (w_state_nxt == PUB);
            if (w_state_nxt == PUB) begin
                r_ch_data <= w_shadow_nxt;
            end
        end
    end

    // Sticky overrun: an INT edge during a burst; set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_rise && ((r_state == RD) || (r_state == PUB))) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

`ifdef INERT_WDOG_EN
    logic [TMO_W-1:0] r_tmo;
    logic             r_stale;

    // Idle watchdog counter, cleared by each INT edge, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (w_rise) begin
            r_tmo <= '0;
        end else if ((r_state == IDLE) && (r_tmo != '1)) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Stale flag: raised on watchdog expiry, dropped with the next publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stale <= 1'b0;
        end else if (w_state_nxt == PUB) begin
            r_stale <= 1'b0;
        end else if ((r_state == IDLE) && (r_tmo == '1)) begin
            r_stale <= 1'b1;
        end
    end

    assign stale = r_stale;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO_W == 0);
    assign stale        = 1'b0;
`endif

    assign wrt     = r_wrt;
    assign cmd     = r_cmd;
    assign ch_data = r_ch_data;
    assign vld     = r_vld;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_inert_poll_seq.sv
// Scoreboard bench for inert_poll_seq: a register-file SPI slave model
// answers reads, the main sequence pushes expected commands and sample sets,
// and a monitor pops and compares on every wrt and vld.
module tb_inert_poll_seq;

    localparam int unsigned NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 INT = 1'b0;
    logic                 wrt;
    logic [15:0]          cmd;
    logic                 done = 1'b0;
    logic [15:0]          rd_data = '0;
    logic [NUM_CH*16-1:0] ch_data;
    logic                 vld;
    logic                 ovr;
    logic                 clr_ovr = 1'b0;
    logic                 stale;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] exp_cmd [$];
    logic [63:0] exp_set [$];
    logic [63:0] last_pub = '0;
    logic [7:0]  mem [128];
    logic [7:0]  ADDRS [NUM_CH] = '{8'h24, 8'h26, 8'h2A, 8'h2C};
    logic [15:0] INIT_EXP [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    int unsigned n_done = 0;
    int unsigned stray_req = 0;
    int unsigned stray_ack = 0;

    inert_poll_seq #(
        .NUM_CH  (NUM_CH),
        .CH_ADDR ({8'h2C, 8'h2A, 8'h26, 8'h24}),
        .SETTLE_W(4),
        .TMO_W   (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (INT),
        .wrt    (wrt),
        .cmd    (cmd),
        .done   (done),
        .rd_data(rd_data),
        .ch_data(ch_data),
        .vld    (vld),
        .ovr    (ovr),
        .clr_ovr(clr_ovr),
        .stale  (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SPI slave: answer each wrt 8 cycles later from the register file
    initial begin
        logic [6:0] a;
        forever begin
            @(negedge clk);
            if (wrt) begin
                a = cmd[14:8];
                repeat (8) @(negedge clk);
                rd_data = {8'h00, mem[a]};
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
                n_done++;
            end else if (stray_req != stray_ack) begin
                rd_data = 16'h00A5;
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
                stray_ack++;
            end
        end
    end

    // Monitor: check each command against the queue, each publish against
    // the expected set, and that ch_data never moves without vld
    initial begin
        bit          pend = 0;
        logic [15:0] held = '0;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (done) pend = 0;
                if (wrt) begin
                    chk("wrt_while_pending", {63'd0, pend}, 64'd0);
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wrt: got cmd %h expected no transaction", cmd);
                    end else begin
                        chk("cmd", {48'd0, cmd}, {48'd0, exp_cmd.pop_front()});
                    end
                    pend = 1;
                    held = cmd;
                end else if (pend) begin
                    chk("cmd_hold", {48'd0, cmd}, {48'd0, held});
                end
                if (vld) begin
                    if (exp_set.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vld: got ch_data %h expected no publish", ch_data);
                    end else begin
                        e = exp_set.pop_front();
                        chk("ch_data_pub", ch_data, e);
                        last_pub = e;
                    end
                end else begin
                    chk("ch_data_hold", ch_data, last_pub);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Fill register file and queue the 8 reads and the resulting set
    task automatic prep_burst(input bit rand_data);
        logic [7:0]  a;
        logic [63:0] s;
        for (int k = 0; k < NUM_CH; k++) begin
            a = ADDRS[k];
            if (rand_data) begin
                mem[a[6:0]]        = 8'($urandom);
                mem[a[6:0] + 7'd1] = 8'($urandom);
            end else begin
                mem[a[6:0]]        = a;
                mem[a[6:0] + 7'd1] = a + 8'd1;
            end
        end
        s = '0;
        for (int b = 0; b < 2 * NUM_CH; b++) begin
            a = ADDRS[b / 2] + 8'(b % 2);
            exp_cmd.push_back({1'b1, a[6:0], 8'hFF});
            s[8 * b +: 8] = mem[a[6:0]];
        end
        exp_set.push_back(s);
    endtask

    task automatic pulse_int();
        @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        int unsigned n = 0;
        while (!vld && n < 300) begin
            cyc(1);
            n++;
        end
        chk(name, {63'd0, vld}, 64'd1);
    endtask

    task automatic wait_dones(input string name, input int unsigned target);
        int unsigned n = 0;
        while (n_done < target && n < 500) begin
            cyc(1);
            n++;
        end
        chk(name, 64'(n_done >= target), 64'd1);
    endtask

    initial begin
        int unsigned base;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);

        // Reset values
        cyc(3);
        chk("rst_wrt", {63'd0, wrt}, 64'd0);
        chk("rst_cmd", {48'd0, cmd}, 64'd0);
        chk("rst_ch_data", ch_data, 64'd0);
        chk("rst_vld", {63'd0, vld}, 64'd0);
        chk("rst_ovr", {63'd0, ovr}, 64'd0);
        chk("rst_stale", {63'd0, stale}, 64'd0);

        // Init sequence, then settle
        for (int i = 0; i < 4; i++) exp_cmd.push_back(INIT_EXP[i]);
        @(negedge clk);
        rst_n = 1'b1;
        wait_dones("init_dones", 4);
        cyc(24);
        chk("init_queue_drained", 64'(exp_cmd.size()), 64'd0);

        // First burst: address echo data
        prep_burst(1'b0);
        pulse_int();
        wait_vld("burst1_vld");
        chk("burst1_set", ch_data, {16'h2D2C, 16'h2B2A, 16'h2726, 16'h2524});
        chk("burst1_ovr", {63'd0, ovr}, 64'd0);
        cyc(5);

        // Random bursts
        for (int r = 0; r < 4; r++) begin
            prep_burst(1'b1);
            pulse_int();
            wait_vld("rand_vld");
            cyc(3 + $urandom_range(0, 6));
        end

        // Overrun: extra INT edge during the third byte
        base = n_done;
        prep_burst(1'b1);
        pulse_int();
        wait_dones("ovr_dones", base + 2);
        pulse_int();
        wait_vld("ovr_vld");
        cyc(120);
        chk("ovr_set", {63'd0, ovr}, 64'd1);
        @(negedge clk);
        clr_ovr = 1'b1;
        cyc(1);
        chk("ovr_cleared", {63'd0, ovr}, 64'd0);
        @(negedge clk);
        clr_ovr = 1'b0;

        // Overrun set coincident with clr_ovr: set must win
        base = n_done;
        prep_burst(1'b1);
        pulse_int();
        wait_dones("ovr2_dones", base + 2);
        @(negedge clk);
        INT = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_ovr = 1'b1;
        cyc(1);
        chk("ovr_set_beats_clr", {63'd0, ovr}, 64'd1);
        @(negedge clk);
        clr_ovr = 1'b0;
        INT = 1'b0;
        wait_vld("ovr2_vld");
        @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        cyc(5);

        // INT held high: one burst only, rearms after a fall
        prep_burst(1'b1);
        @(negedge clk);
        INT = 1'b1;
        wait_vld("held_vld");
        cyc(150);
        @(negedge clk);
        INT = 1'b0;
        cyc(5);
        prep_burst(1'b1);
        pulse_int();
        wait_vld("rearm_vld");
        chk("held_ovr", {63'd0, ovr}, 64'd0);

        // Stray done in IDLE must be ignored
        cyc(5);
        stray_req++;
        cyc(20);
        prep_burst(1'b1);
        pulse_int();
        wait_vld("after_stray_vld");

`ifdef INERT_WDOG_EN
        cyc(40);
        chk("stale_early", {63'd0, stale}, 64'd0);
        cyc(40);
        chk("stale_set", {63'd0, stale}, 64'd1);
        prep_burst(1'b1);
        pulse_int();
        wait_vld("stale_vld");
        chk("stale_clr", {63'd0, stale}, 64'd0);
`else
        cyc(80);
        chk("stale_tied", {63'd0, stale}, 64'd0);
`endif

        cyc(40);
        chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        chk("set_queue_empty", 64'(exp_set.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
